// File: rtl/peach_pkg.sv
// Shared control-path definitions: state encoding, PC source select codes and
// base opcodes shared with the instruction decoder.
package peach_pkg;

  typedef enum logic [7:0] {
    ST_FETCH  = 8'h00,
    ST_DECODE = 8'h01,
    ST_EXEC   = 8'h02,
    ST_MEM    = 8'h03,
    ST_WB     = 8'h04,
    ST_TRAP   = 8'h05,
    ST_BOOT   = 8'hFF
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_ZERO   = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // A decoded instruction is legal only when exactly one class flag is set.
  function automatic logic class_is_legal(input logic [5:0] flags);
    return ($countones(flags) == 1);
  endfunction

endpackage

// File: rtl/mc_control_boot_counter.sv
// 16-bit word index for the ROM-to-memory boot copy; stops at its terminal
// value and flags it.
module boot_counter #(
  parameter logic [15:0] TC_VALUE = 16'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count,
  output logic        tc
);

  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 16'd0;
    end else if (en && !tc) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == TC_VALUE);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle CPU control FSM: boot copy, fetch/decode/exec/mem/writeback.
// Build option PEACH_TRAP_EN halts in TRAP on an illegal opcode instead of skipping it.
module mc_control
  import peach_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        type_r,
  input  logic        type_i,
  input  logic        type_s,
  input  logic        type_b,
  input  logic        type_u,
  input  logic        type_j,
  input  logic        is_load,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic [15:0] boot_addr,
  output logic        boot_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [7:0]  state,
  output logic        trap
);

  localparam logic [15:0] BOOT_LAST = 16'(ROM_WORDS - 1);

  state_t state_reg, state_next;
  logic   boot_tc;
  logic   legal;

  boot_counter #(
    .TC_VALUE (BOOT_LAST)
  ) u_boot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_reg == ST_BOOT),
    .count (boot_addr),
    .tc    (boot_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  assign legal = class_is_legal({type_r, type_i, type_s, type_b, type_u, type_j});

  always_comb begin
    state_next = state_reg;
    boot_we    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_SEL_PLUS4;
    case (state_reg)
      ST_BOOT: begin
        boot_we = 1'b1;
        if (boot_tc) begin
          pc_we      = 1'b1;
          pc_sel     = PC_SEL_ZERO;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_next = ST_EXEC;
        end else begin
`ifdef PEACH_TRAP_EN
          state_next = ST_TRAP;
`else
          pc_we      = 1'b1;
          pc_sel     = PC_SEL_PLUS4;
          state_next = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        if (type_b) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
          state_next = ST_FETCH;
        end else if (type_s || is_load) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        // Loads finish through WB; stores have no register result and retire here.
        if (is_load) begin
          mem_re = 1'b1;
          if (mem_ready) state_next = ST_WB;
        end else begin
          mem_we = 1'b1;
          if (mem_ready) begin
            pc_we      = 1'b1;
            pc_sel     = PC_SEL_PLUS4;
            state_next = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = type_j ? PC_SEL_TARGET : PC_SEL_PLUS4;
        state_next = ST_FETCH;
      end
      default: begin
        state_next = state_reg;
      end
    endcase
    // Strobes must be quiet for the whole time reset is held, not just after an edge.
    if (!rst_n) begin
      boot_we = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = PC_SEL_PLUS4;
    end
  end

  assign state = state_reg;

`ifdef PEACH_TRAP_EN
  assign trap = (state_reg == ST_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule
